// File: rtl/datapath_ctrl.sv
// RV32 R-type decode controller that sequences a register-file/ALU datapath.
// Define DATAPATH_CTRL_DIV_EN to decode DIV and build the multi-cycle WAIT state.
module datapath_ctrl #(
    parameter int unsigned DIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        zero_flag,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rw,
    output logic [6:0]  operation,
    output logic        write,
    output logic        done,
    output logic        err,
    output logic        zero_out
);

    localparam logic [6:0] ADD     = 7'd1;
    localparam logic [6:0] SUB     = 7'd2;
    localparam logic [6:0] AND     = 7'd3;
    localparam logic [6:0] OR      = 7'd4;
    localparam logic [6:0] OpcodeR = 7'b0110011;
`ifdef DATAPATH_CTRL_DIV_EN
    localparam logic [6:0] DIV      = 7'd5;
    // WAIT runs DIV_CYCLES-1 cycles: count from DIV_CYCLES-2 down to 0.
    localparam logic [3:0] WaitLoad = 4'(DIV_CYCLES - 2);
`endif

    if (DIV_CYCLES < 2 || DIV_CYCLES > 15) begin : g_bad_div_cycles
        $error("DIV_CYCLES must be in the range 2..15");
    end

    typedef enum logic [2:0] {StIdle, StExec, StWait, StWb, StErr} state_e;

    state_e     state_q;
    logic [4:0] rs1_q, rs2_q, rw_q;
    logic [6:0] op_q;
    logic       write_q, done_q, err_q, zero_q;
`ifdef DATAPATH_CTRL_DIV_EN
    logic [3:0] cnt_q;
`endif

    logic       dec_legal;
    logic [6:0] dec_op;

    always_comb begin
        dec_legal = 1'b0;
        dec_op    = ADD;
        if (instr[6:0] == OpcodeR) begin
            case ({instr[31:25], instr[14:12]})
                {7'b0000000, 3'b000}: begin dec_legal = 1'b1; dec_op = ADD; end
                {7'b0100000, 3'b000}: begin dec_legal = 1'b1; dec_op = SUB; end
                {7'b0000000, 3'b111}: begin dec_legal = 1'b1; dec_op = AND; end
                {7'b0000000, 3'b110}: begin dec_legal = 1'b1; dec_op = OR;  end
`ifdef DATAPATH_CTRL_DIV_EN
                {7'b0000001, 3'b100}: begin dec_legal = 1'b1; dec_op = DIV; end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rw_q    <= '0;
            op_q    <= '0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            zero_q  <= 1'b0;
`ifdef DATAPATH_CTRL_DIV_EN
            cnt_q   <= '0;
`endif
        end else begin
            write_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        rs1_q <= instr[19:15];
                        rs2_q <= instr[24:20];
                        rw_q  <= instr[11:7];
                        if (dec_legal) begin
                            op_q    <= dec_op;
                            state_q <= StExec;
                        end else begin
                            state_q <= StErr;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
                StExec: begin
`ifdef DATAPATH_CTRL_DIV_EN
                    if (op_q == DIV) begin
                        cnt_q   <= WaitLoad;
                        state_q <= StWait;
                    end else begin
                        state_q <= StWb;
                        done_q  <= 1'b1;
                        write_q <= (rw_q != 5'd0);
                        zero_q  <= zero_flag;
                    end
`else
                    state_q <= StWb;
                    done_q  <= 1'b1;
                    write_q <= (rw_q != 5'd0);
                    zero_q  <= zero_flag;
`endif
                end
`ifdef DATAPATH_CTRL_DIV_EN
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StWb;
                        done_q  <= 1'b1;
                        write_q <= (rw_q != 5'd0);
                        zero_q  <= zero_flag;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
`endif
                StWb:    state_q <= StIdle;
                StErr:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign rw        = rw_q;
    assign operation = op_q;
    assign write     = write_q;
    assign done      = done_q;
    assign err       = err_q;
    assign zero_out  = zero_q;

endmodule

// File: doc/datapath_ctrl.md
DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 Parameter: DIV_CYCLES, 4, number of execute cycles for DIV (legal range 2..15).
REQ-002 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 instr  input  32  RV32 instruction word; sampled only on an accept.
REQ-005 in_valid  input  1  instr is valid.
REQ-006 in_ready  output  1  controller can accept an instruction.
REQ-007 zero_flag  input  1  datapath ALU zero result.
REQ-008 rs1, rs2, rw  output  5 each  datapath register addresses.
REQ-009 operation  output  7  datapath ALU opcode, using the team constants ADD, SUB, AND, OR and DIV.
REQ-010 write  output  1  datapath register-file write enable.
REQ-011 done  output  1  one-cycle pulse when an instruction retires.
REQ-012 err  output  1  one-cycle pulse, coincident with done, when an illegal instruction retires.
REQ-013 zero_out  output  1  captured zero_flag of the last retired legal instruction.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, EXEC, WAIT, WB, ERR.
REQ-015 in_ready SHALL be 1 only in IDLE; an accept is in_valid & in_ready at a rising edge.
REQ-016 On accept, the block SHALL decode instr and register rs1=instr[19:15], rs2=instr[24:20], rw=instr[11:7] and operation.
REQ-017 Decode, keyed on opcode 0110011 plus funct3/funct7:
- 000/0000000 -> ADD
- 000/0100000 -> SUB
- 111/0000000 -> AND
- 110/0000000 -> OR
- 100/0000001 -> DIV
REQ-018 Any other opcode or funct combination SHALL be illegal: IDLE->ERR.
REQ-019 A legal instruction SHALL transition IDLE->EXEC; from EXEC it goes to WB for non-DIV, or to WAIT for DIV.
REQ-020 WAIT SHALL hold for DIV_CYCLES-1 cycles using a 4-bit down-counter, then go to WB.
REQ-021 Latency, accept edge to done high:
- non-DIV: 2 cycles
- DIV: DIV_CYCLES+1 cycles
- illegal: 1 cycle
REQ-022 rs1, rs2, rw and operation SHALL remain stable from EXEC through WB and SHALL hold their values in IDLE.
REQ-023 zero_out SHALL load zero_flag on the edge entering WB; ERR SHALL leave zero_out unchanged.
REQ-024 In WB, write SHALL be 1 unless rw==0, in which case no write is issued; done SHALL be 1; next state is IDLE.
REQ-025 In ERR: write=0, done=1, err=1; next state is IDLE.
REQ-026 write, done and err SHALL be 0 in every other state.
REQ-027 in_valid asserted outside IDLE SHALL be ignored; no instruction is queued.
REQ-028 Back-to-back operation: a new accept SHALL be possible in the IDLE cycle immediately after WB or ERR; the maximum throughput is one instruction per 3 cycles.

Reset
REQ-029 Asserting reset (low) SHALL immediately force state=IDLE, in_ready=1, write=0, done=0, err=0, zero_out=0, rs1=rs2=rw=0, operation=0 and WAIT counter=0.
REQ-030 Reset asserted mid-instruction (EXEC, WAIT or WB) SHALL abort it with no write and no done pulse.
REQ-031 Operation SHALL resume from IDLE on the first rising edge after reset deasserts.

Configuration
REQ-032 Macro DATAPATH_CTRL_DIV_EN:
- defined: DIV is decoded per REQ-017 and uses WAIT.
- undefined: funct7=0000001 is illegal (ERR), and the WAIT state and its counter are not synthesised.

Verification
REQ-033 ADD x3,x5,x27 accepted at cycle 0 -> EXEC at cycle 1; at cycle 2: rs1=5, rs2=27, rw=3, operation=ADD, write=1, done=1.
REQ-034 SUB x1,x14,x14 with zero_flag=1 during EXEC -> zero_out=1 in WB; a following OR with zero_flag=0 -> zero_out=0.
REQ-035 DIV x4,x2,x21 with DIV_EN defined and DIV_CYCLES=4 -> done at cycle 5, write=1 for exactly one cycle; with DIV_EN undefined -> err=1 and done=1 at cycle 1, write=0.
REQ-036 Opcode 0010011 instruction -> ERR, err and done pulse at cycle 1, write=0; an AND with rw=0 -> done=1, write=0.
REQ-037 Reset low during WAIT of a DIV -> outputs zero immediately, no done; after release, an OR x7,x9 completes normally.
REQ-038 in_valid held high for 10 cycles with successive ADD instructions -> accepts at cycles 0, 3, 6 and 9 only, and every accepted instruction retires.
